// File: rtl/expand3_bias_relu_if.sv
// ============================================================================
// expand3_bias_relu_if : accumulator-in / activation-out stream bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface expand3_bias_relu_if #(
  parameter int ACC_W = 32,
  parameter int CH_W  = 6
);
  logic [ACC_W-1:0] acc_data;
  logic             acc_valid;
  logic             acc_ready;
  logic [15:0]      out_data;
  logic [CH_W-1:0]  out_ch;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output acc_data, acc_valid, out_ready,
    input  acc_ready, out_data, out_ch, out_last, out_valid
  );

  modport slave (
    input  acc_data, acc_valid, out_ready,
    output acc_ready, out_data, out_ch, out_last, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/expand3_bias_relu.sv
// ============================================================================
// expand3_bias_relu : fire3 expand3 post-MAC stage (bias, round, shift,
// saturate, optional ReLU). Optional ReLU: define EXPAND3_BIAS_RELU_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module expand3_bias_relu #(
  parameter int ACC_W     = 32,
  parameter int NUM_CH    = 64,
  parameter int CH_W      = 6,
  parameter int OUT_SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0][15:0] bias_mem,
  input  logic                   ch_clr,
  expand3_bias_relu_if.slave     bus
);

  localparam logic [CH_W-1:0]         c_LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic signed [ACC_W+1:0] c_ONE     = {{(ACC_W+1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W+1:0] c_RND     = (c_ONE << OUT_SHIFT) >>> 1;
  localparam logic signed [ACC_W+1:0] c_MAX     = (ACC_W+2)'(32767);
  localparam logic signed [ACC_W+1:0] c_MIN     = -c_MAX;

  logic                    w_s1_adv;
  logic                    w_s2_adv;
  logic                    w_accept;
  logic [CH_W-1:0]         r_ch_cnt;
  logic [CH_W-1:0]         w_ch;
  logic [15:0]             w_bias_word;
  logic signed [ACC_W:0]   w_bias_mag;
  logic signed [ACC_W:0]   w_bias;
  logic signed [ACC_W:0]   w_sum;

  logic                    r_s1_valid;
  logic signed [ACC_W:0]   r_s1_sum;
  logic [CH_W-1:0]         r_s1_ch;
  logic                    r_s1_last;

  logic signed [ACC_W+1:0] w_rnd;
  logic signed [ACC_W+1:0] w_shr;
  logic signed [ACC_W+1:0] w_abs;
  logic [15:0]             w_act;
  logic                    w_unused;

  logic                    r_s2_valid;
  logic [15:0]             r_out_data;
  logic [CH_W-1:0]         r_out_ch;
  logic                    r_out_last;

  // Each stage moves when its successor can take the beat, so bubbles collapse.
  assign w_s2_adv      = !r_s2_valid || bus.out_ready;
  assign w_s1_adv      = !r_s1_valid || w_s2_adv;
  assign w_accept      = bus.acc_valid && w_s1_adv;
  assign bus.acc_ready = w_s1_adv;

  assign w_ch        = ch_clr ? '0 : r_ch_cnt;
  assign w_bias_word = bias_mem[w_ch];
  assign w_bias_mag  = $signed({{(ACC_W-14){1'b0}}, w_bias_word[14:0]});
  assign w_bias      = w_bias_word[15] ? -w_bias_mag : w_bias_mag;
  assign w_sum       = $signed({bus.acc_data[ACC_W-1], bus.acc_data}) + w_bias;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_cnt <= '0;
    end else if (w_accept) begin
      r_ch_cnt <= (w_ch == c_LAST_CH) ? '0 : w_ch + 1'b1;
    end else if (ch_clr) begin
      r_ch_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_ch    <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sum  <= w_sum;
        r_s1_ch   <= w_ch;
        r_s1_last <= (w_ch == c_LAST_CH);
      end
    end
  end

  // One guard bit above the sum keeps the rounding add from overflowing.
  assign w_rnd    = $signed({r_s1_sum[ACC_W], r_s1_sum}) + c_RND;
  assign w_shr    = w_rnd >>> OUT_SHIFT;
  assign w_abs    = w_shr[ACC_W+1] ? -w_shr : w_shr;
  assign w_unused = ^w_abs[ACC_W+1:15];

  always_comb begin
    w_act = 16'h0000;
    if (w_shr > c_MAX) begin
      w_act = 16'h7FFF;
    end else if (w_shr < c_MIN) begin
      w_act = 16'hFFFF;
    end else if (w_shr[ACC_W+1]) begin
      w_act = {1'b1, w_abs[14:0]};
    end else begin
      w_act = {1'b0, w_shr[14:0]};
    end
`ifdef EXPAND3_BIAS_RELU_EN
    if (w_act[15]) begin
      w_act = 16'h0000;
    end
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_ch   <= '0;
      r_out_last <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_act;
        r_out_ch   <= r_s1_ch;
        r_out_last <= r_s1_last;
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_last  = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_expand3_bias_relu.sv
// ============================================================================
// tb_expand3_bias_relu : randomized bench with queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_expand3_bias_relu;

  localparam int ACC_W     = 32;
  localparam int NUM_CH    = 64;
  localparam int CH_W      = 6;
  localparam int OUT_SHIFT = 0;

  typedef struct {
    logic [15:0] d;
    int          ch;
    bit          last;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    ch_clr = 1'b0;
  logic [NUM_CH-1:0][15:0] bias_mem;
  int                      n_checks = 0;
  int                      n_fail = 0;
  int                      ready_mode = 0;
  exp_t                    exp_q[$];
  int                      ch_model = 0;

  expand3_bias_relu_if #(.ACC_W(ACC_W), .CH_W(CH_W)) bus ();

  expand3_bias_relu #(
    .ACC_W(ACC_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bias_mem(bias_mem),
    .ch_clr  (ch_clr),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_act(input longint acc, input logic [15:0] b);
    longint bias, v;
    bias = longint'(b[14:0]);
    if (b[15]) bias = -bias;
    v = acc + bias;
    if (OUT_SHIFT > 0) v = (v + ((longint'(1) << OUT_SHIFT) / 2)) >>> OUT_SHIFT;
    if (v > 32767)  v = 32767;
    if (v < -32767) v = -32767;
    if (v < 0) begin
`ifdef EXPAND3_BIAS_RELU_EN
      return 16'h0000;
`else
      return {1'b1, 15'(-v)};
`endif
    end
    return 16'(v);
  endfunction

  // Monitor: model accepted beats, compare every presented output to the queue head.
  initial begin
    exp_t e;
    int   ch;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        ch_model = 0;
      end else begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
          end else begin
            check("out_data", 32'(bus.out_data), 32'(exp_q[0].d));
            check("out_ch",   32'(bus.out_ch),   32'(exp_q[0].ch));
            check("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
        if (bus.acc_valid && bus.acc_ready) begin
          ch     = ch_clr ? 0 : ch_model;
          e.d    = ref_act(longint'($signed(bus.acc_data)), bias_mem[ch]);
          e.ch   = ch;
          e.last = (ch == NUM_CH - 1);
          exp_q.push_back(e);
          ch_model = (ch + 1) % NUM_CH;
        end else if (ch_clr) begin
          ch_model = 0;
        end
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [31:0] d, input bit clr, output int waits);
    bus.acc_data  = d;
    bus.acc_valid = 1'b1;
    ch_clr        = clr;
    waits         = 0;
    forever begin
      @(negedge clk);
      if (bus.acc_ready) break;
      waits++;
      if (waits > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    bus.acc_valid = 1'b0;
    ch_clr        = 1'b0;
  endtask

  function automatic logic [31:0] rand_acc();
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'($signed(32'($urandom_range(0, 80000))) - 40000);
      2:       return 32'($signed(32'($urandom_range(0, 600))) - 300);
      default: return 32'($signed(32'($urandom_range(0, 70000))) - 35000);
    endcase
  endfunction

  initial begin
    int w, total;
    bus.acc_valid = 1'b0;
    bus.acc_data  = '0;
    for (int i = 0; i < NUM_CH; i++) bias_mem[i] = 16'($urandom());
    bias_mem[0] = 16'h0010;
    bias_mem[1] = 16'h8090;
    bias_mem[2] = 16'h0010;
    bias_mem[3] = 16'h8010;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_ch",    32'(bus.out_ch),    32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_acc_ready", 32'(bus.acc_ready), 32'd1);

    // Two-cycle latency from accept to out_valid.
    @(posedge clk);
    #1;
    bus.acc_data  = 32'd100;
    bus.acc_valid = 1'b1;
    @(negedge clk);
    check("lat_accept", 32'(bus.acc_ready), 32'd1);
    @(posedge clk);
    #1 bus.acc_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
    check("lat_data",         32'(bus.out_data),  32'h0074);
    check("lat_ch",           32'(bus.out_ch),    32'd0);
    @(posedge clk);
    #1;

    send(32'd50, 1'b0, w);
    send(32'd40000, 1'b0, w);
    send(-32'sd40000, 1'b0, w);
    repeat (3) @(posedge clk);
    #1;

    ch_clr = 1'b1;
    @(posedge clk);
    #1 ch_clr = 1'b0;

    total = 0;
    for (int i = 0; i < NUM_CH + 1; i++) begin
      send(rand_acc(), 1'b0, w);
      total += w;
    end
    check("burst_stall_cycles", 32'(total), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Output stall mid-stream: channels 1..12.
    fork
      begin
        for (int i = 0; i < 12; i++) send(rand_acc(), 1'b0, w);
      end
      begin
        repeat (3) @(posedge clk);
        ready_mode = 2;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("stall_acc_ready", 32'(bus.acc_ready), 32'd0);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        ready_mode = 0;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Counter now 13; advance to 17, then clear with an accepted beat.
    for (int i = 0; i < 4; i++) send(rand_acc(), 1'b0, w);
    send(rand_acc(), 1'b1, w);
    send(rand_acc(), 1'b0, w);
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < NUM_CH; i++) bias_mem[i] = 16'($urandom());
    bias_mem[5] = 16'h8000;
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(rand_acc(), ($urandom_range(0, 15) == 0), w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    ready_mode = 0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    // Reset with two beats in flight.
    send(rand_acc(), 1'b0, w);
    send(rand_acc(), 1'b0, w);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(bus.out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
